// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16x16 shift-and-add multiplier (low 16 bits) that
// sequences a shared 16-bit ALU through add and single-bit shift steps.
module alu_mul_sequencer #(
  parameter logic [3:0] IDLE_OPCODE = 4'h5,
  parameter int MAX_ITER = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_multiplicand,
  input  logic [15:0] i_multiplier,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product,
  output logic [3:0]  o_alu_opcode,
  output logic [1:0]  o_alu_extra,
  output logic [15:0] o_alu_data1,
  output logic [15:0] o_alu_data2,
  output logic [7:0]  o_alu_const,
  input  logic [15:0] i_alu_result
);
  localparam int IW = $clog2(MAX_ITER + 1);
  typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, SHR, DONE} state_t;
  state_t state, state_next;
  logic [15:0] a, b, p;
  logic [IW-1:0] iter;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      p <= '0;
      iter <= '0;
      o_product <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (i_start) begin
          a <= i_multiplicand;
          b <= i_multiplier;
          p <= '0;
          iter <= '0;
        end
        ADD: p <= i_alu_result;
        SHL: a <= i_alu_result;
        SHR: begin
          b <= i_alu_result;
          iter <= iter + 1'b1;
        end
        DONE: o_product <= p;
        default: ;
      endcase
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = i_start ? TEST : IDLE;
      TEST: state_next = (b == '0 || iter == IW'(MAX_ITER)) ? DONE : b[0] ? ADD : SHL;
      ADD:  state_next = SHL;
      SHL:  state_next = SHR;
      SHR:  state_next = TEST;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state != IDLE;
    o_done = state == DONE;
    o_alu_opcode = state == ADD ? 4'h0 : (state == SHL || state == SHR) ? 4'h4 : IDLE_OPCODE;
    o_alu_extra = state == SHL ? 2'b11 : state == SHR ? 2'b10 : 2'b00;
    o_alu_data1 = state == ADD ? p : state == SHL ? a : state == SHR ? b : 16'h0;
    o_alu_data2 = state == ADD ? a : 16'h0;
    o_alu_const = (state == SHL || state == SHR) ? 8'd1 : 8'd0;
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that performs 16x16 unsigned multiplication (low 16 bits) by sequencing the shared 16-bit ALU through shift-and-add steps.
- Drives the ALU opcode, extra, data1, data2 and const inputs, and captures the ALU result on each clock edge.
- Sits beside the CPU control unit. The core starts an operation with a one-cycle request and receives a done pulse with the product.

Parameters:
- IDLE_OPCODE, 4'h5: opcode driven while the ALU is not in use (LOAD, ALU output 0).
- MAX_ITER, 16: hard cap on loop iterations; equals the data width.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_multiplicand  in  16  operand A; latched on start accept.
- i_multiplier  in  16  operand B; latched on start accept.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse in the DONE state.
- o_product  out  16  result (A*B) mod 2^16; held until the next result is written.
- o_alu_opcode  out  4  to ALU i_opcode.
- o_alu_extra  out  2  to ALU i_extra.
- o_alu_data1  out  16  to ALU i_data1.
- o_alu_data2  out  16  to ALU i_data2.
- o_alu_const  out  8  to ALU i_const.
- i_alu_result  in  16  from ALU o_data; combinational, same cycle.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; internal regs A, B, P and iter all 0.
  - o_busy=0, o_done=0, o_product=0.
  - ALU outputs take their idle values (see ALU drive below).
- Reset mid-operation aborts the operation with no o_done pulse.
- IDLE:
  - If i_start=1: latch A=i_multiplicand, B=i_multiplier, P=0, iter=0; go to TEST.
  - Otherwise stay in IDLE.
- TEST (ALU idle):
  - If B==0 or iter==MAX_ITER: go to DONE.
  - Else if B[0]=1: go to ADD.
  - Else: go to SHL.
- ADD: opcode=4'h0, extra=2'b00, data1=P, data2=A; P<=i_alu_result; go to SHL.
- SHL: opcode=4'h4, extra=2'b11 (shift left, amount from const), data1=A, const=8'd1; A<=i_alu_result; go to SHR.
- SHR: opcode=4'h4, extra=2'b10 (shift right, amount from const), data1=B, const=8'd1; B<=i_alu_result; iter<=iter+1; go to TEST.
- DONE: o_done=1, o_product<=P (registered at the exit edge, so o_product is valid from the cycle after o_done); go to IDLE.
- ALU drive:
  - Any state other than ADD, SHL or SHR drives opcode=IDLE_OPCODE, extra=0, data1=0, data2=0, const=0.
  - Outputs are a pure function of state and internal regs; no glitch requirements.
- Arithmetic: all adds and shifts wrap modulo 2^16. Overflow is discarded silently; there is no flag.
- i_start while busy is ignored, not queued. i_start in the DONE cycle is also ignored. i_start in the IDLE cycle right after DONE is accepted.
- Operand inputs are don't-care except on the accept edge.
- Latency from accept edge: the state sequence is TEST, then per iteration (ADD,)SHL,SHR, then TEST, DONE. Worst case (B=16'hFFFF) is 1+16*4+1 = 66 cycles to DONE.
- o_busy is combinational from state and is high during TEST, ADD, SHL, SHR and DONE.

Test Plan:
- Reset mid-operation: start with A=7, B=9; assert i_reset in the ADD state. Required: o_busy=0 and o_done=0 at once, o_product=0, ALU opcode=4'h5; a new start afterwards completes normally.
- Small product: A=3, B=5. Required: states TEST,ADD,SHL,SHR,TEST,SHL,SHR,TEST,ADD,SHL,SHR,TEST,DONE; o_done in the 13th cycle after accept; o_product=15; ADD cycles show opcode 0 with data1=0 then data1=3.
- Zero multiplier: A=16'h1234, B=0. Required: TEST then DONE; o_done 2 cycles after accept; o_product=0; no ADD or SHIFT opcodes issued.
- Overflow wrap: A=16'h0100, B=16'h0100. Required: o_product=16'h0000. A=16'hFFFF, B=16'hFFFF. Required: o_product=16'h0001, o_done at cycle 66.
- Start while busy: pulse i_start with new operands every cycle during a 3*5 run. Required: result is 15 and only one o_done pulse. Start with A=4, B=4 the cycle after DONE. Required: accepted, o_product=16.
- Product hold: after 6*7 completes, hold i_start=0 for 20 cycles. Required: o_product stays 42, o_busy=0, ALU inputs held at idle values.
